rr_reg_arbiter: RTL and testbench

Round-robin arbiter that shares one W-bit edge-triggered storage register between N requesters. Each requester raises a request, receives a one-hot grant, writes the shared register while it owns it, and releases by dropping its request. The block sits in front of the flip-flop storage and sequences every access to it, so no two requesters can drive the register in the same cycle.

---
 rtl/rr_arb_pkg.sv | 17 +
 rtl/rr_reg_arbiter_if.sv | 28 ++
 rtl/rr_reg_arbiter_shared_reg.sv | 26 ++
 rtl/rr_reg_arbiter.sv | 170 +++++++++++++++++
 tb/tb_rr_reg_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types, widths and reset constant for rr_reg_arbiter
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Value the shared register takes on reset; sliced to W bits by users
  localparam logic [63:0] Q_RST_VAL = 64'h0;

  // Width of an index that can name any of n requesters (at least 1 bit)
  function automatic int owner_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// rtl/rr_reg_arbiter_if.sv - requester-side bus of the shared register arbiter
interface rr_reg_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  import rr_arb_pkg::*;

  localparam int OW = owner_w(N);

  logic [N-1:0]   REQ;
  logic [N-1:0]   WE;
  logic [N*W-1:0] D;
  logic [N-1:0]   GNT;
  logic [W-1:0]   Q;
  logic           BUSY;
  logic [OW-1:0]  OWNER;

  modport master (
    output REQ, WE, D,
    input  GNT, Q, BUSY, OWNER
  );

  modport slave (
    input  REQ, WE, D,
    output GNT, Q, BUSY, OWNER
  );

endinterface

// File: rtl/rr_reg_arbiter_shared_reg.sv
// rtl/rr_reg_arbiter_shared_reg.sv - W-bit storage register with sync active-low reset and enable
module shared_reg #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         CK,
  input  logic         RST_N,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Reset wins over a pending write; otherwise load only when enabled
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/rr_reg_arbiter.sv
// rtl/rr_reg_arbiter.sv - round-robin arbiter owning one shared register; ARB_TIMEOUT_EN adds forced release
module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             CK,
  input  logic             RST_N,
  rr_reg_arbiter_if.slave  bus
);

  localparam int OW = owner_w(N);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    w_gnt_nxt;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   w_owner_nxt;
  logic [OW-1:0]   r_ptr;
  logic [OW-1:0]   w_ptr_nxt;
  logic            r_busy;
  logic            w_busy_nxt;

  logic            w_found;
  logic [OW-1:0]   w_sel;
  logic [OW-1:0]   w_idx;
  logic [OW-1:0]   w_ptr_after_owner;
  logic            w_req_own;
  logic            w_we_own;
  logic [W-1:0]    w_wdata;
  logic            w_wr_en;
  logic [W-1:0]    w_q;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  logic [HW-1:0]   r_hold;
  logic [HW-1:0]   w_hold_nxt;
  logic            w_hold_expired;
  assign w_hold_expired = (r_hold == HW'(MAX_HOLD - 1));
`else
  logic            w_unused_max_hold;
  assign w_unused_max_hold = (MAX_HOLD > 0);
`endif

  // Pick the first requester at or after the pointer, wrapping past N-1
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = OW'((int'(r_ptr) + k) % N);
      if (!w_found && bus.REQ[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Owner's request, write enable and data; non-owner lanes never reach the register
  always_comb begin
    w_req_own = bus.REQ[r_owner];
    w_we_own  = bus.WE[r_owner];
    w_wdata   = '0;
    for (int i = 0; i < N; i++) begin
      if (r_owner == OW'(i)) begin
        w_wdata = bus.D[i*W +: W];
      end
    end
  end

  assign w_ptr_after_owner = (r_owner == OW'(N - 1)) ? '0 : r_owner + 1'b1;

  // Next-state, grant and write-enable decode for the IDLE/OWN sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    w_wr_en     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_hold_nxt  = r_hold;
`endif
    case (r_state)
      IDLE: begin
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
        if (w_found) begin
          w_gnt_nxt[w_sel] = 1'b1;
          w_owner_nxt      = w_sel;
          w_busy_nxt       = 1'b1;
          w_state_nxt      = OWN;
`ifdef ARB_TIMEOUT_EN
          w_hold_nxt       = '0;
`endif
        end
      end
      OWN: begin
        if (w_req_own) begin
          // Write lands even on the cycle a forced release fires
          w_wr_en = w_we_own;
`ifdef ARB_TIMEOUT_EN
          if (w_hold_expired) begin
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_ptr_nxt   = w_ptr_after_owner;
            w_state_nxt = IDLE;
          end else begin
            w_hold_nxt  = r_hold + 1'b1;
          end
`endif
        end else begin
          // Voluntary release: any write asserted in this cycle is dropped
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = w_ptr_after_owner;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Arbiter state register; reset clears grant, owner and pointer
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
`ifdef ARB_TIMEOUT_EN
      r_hold  <= w_hold_nxt;
`endif
    end
  end

  shared_reg #(
    .W       (W),
    .RST_VAL (W'(Q_RST_VAL))
  ) u_shared_reg (
    .CK    (CK),
    .RST_N (RST_N),
    .i_en  (w_wr_en),
    .i_d   (w_wdata),
    .o_q   (w_q)
  );

  assign bus.GNT   = r_gnt;
  assign bus.Q     = w_q;
  assign bus.BUSY  = r_busy;
  assign bus.OWNER = r_owner;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb/tb_rr_reg_arbiter.sv - randomized and directed check of rr_reg_arbiter against a behavioural model
module tb_rr_reg_arbiter;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_HOLD = 4;

  logic CK;
  logic RST_N;

  rr_reg_arbiter_if #(.N(N), .W(W)) bus ();

  rr_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .CK    (CK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the register (-1 = nobody), where the scan starts,
  // last owner, cycles spent owning, and register contents
  int         m_own  = -1;
  int         m_ptr  = 0;
  int         m_last = 0;
  int         m_hold = 0;
  logic [7:0] m_q    = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] d;
    req = bus.REQ;
    we  = bus.WE;
    d   = bus.D;
    if (!RST_N) begin
      m_own = -1; m_ptr = 0; m_last = 0; m_hold = 0; m_q = 8'h00;
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_own < 0 && req[c]) begin
          m_own  = c;
          m_last = c;
          m_hold = 0;
        end
      end
    end else if (!req[m_own]) begin
      m_ptr = (m_own + 1) % N;
      m_own = -1;
    end else begin
      if (we[m_own]) m_q = d[m_own*8 +: 8];
`ifdef ARB_TIMEOUT_EN
      if (m_hold == MAX_HOLD - 1) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
      end else begin
        m_hold++;
      end
`endif
    end
  endtask

  task automatic compare_all();
    chk("gnt",    32'(bus.GNT),   (m_own < 0) ? 32'd0 : (32'd1 << m_own));
    chk("busy",   32'(bus.BUSY),  (m_own < 0) ? 32'd0 : 32'd1);
    chk("owner",  32'(bus.OWNER), 32'(m_last));
    chk("q",      32'(bus.Q),     32'(m_q));
    chk("onehot", 32'($onehot0(bus.GNT)), 32'd1);
  endtask

  // One clock: apply inputs, advance the model on the edge, check on the falling edge
  task automatic cyc(input logic rst_n, input logic [3:0] req, input logic [3:0] we,
                     input logic [31:0] d);
    RST_N   = rst_n;
    bus.REQ = req;
    bus.WE  = we;
    bus.D   = d;
    @(posedge CK);
    model_step();
    @(negedge CK);
    compare_all();
  endtask

  initial begin
    logic [3:0]  r_req;
    int          run;
    bit          ended;
    logic [3:0]  exp_order [5];
    RST_N   = 1'b0;
    bus.REQ = '0;
    bus.WE  = '0;
    bus.D   = '0;

    // Reset values, then a single grant one edge after REQ
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0);
    chk("rst_gnt", 32'(bus.GNT), 32'h0);
    chk("rst_q", 32'(bus.Q), 32'h0);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);
    chk("rst_owner", 32'(bus.OWNER), 32'h0);
    cyc(1'b1, 4'b0010, 4'b0000, 32'h0);
    chk("first_gnt", 32'(bus.GNT), 32'h2);
    cyc(1'b1, 4'b0000, 4'b0000, 32'h0);

    // Round-robin order with every owner releasing after one OWN cycle
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0);
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int g = 0; g < 5; g++) begin
      cyc(1'b1, 4'b1111, 4'b0000, 32'h0);
      chk("rr_gnt", 32'(bus.GNT), 32'(exp_order[g]));
      cyc(1'b1, 4'b1111 & ~bus.GNT, 4'b0000, 32'h0);
      chk("rr_gap", 32'(bus.GNT), 32'h0);
    end

    // Write isolation: owner 1 writes A5 while non-owner 2 offers 3C
    cyc(1'b1, 4'b0110, 4'b0000, 32'h0);
    chk("iso_gnt", 32'(bus.GNT), 32'h2);
    cyc(1'b1, 4'b0110, 4'b0110, 32'h003C_A500);
    chk("iso_q", 32'(bus.Q), 32'hA5);
    cyc(1'b1, 4'b0110, 4'b0100, 32'h003C_0000);
    chk("iso_q_hold", 32'(bus.Q), 32'hA5);

    // Release cycle write is dropped
    cyc(1'b1, 4'b0100, 4'b0010, 32'h0000_FF00);
    chk("rel_q", 32'(bus.Q), 32'hA5);
    chk("rel_gnt", 32'(bus.GNT), 32'h0);

    // Reset mid-ownership clears Q and the pointer
    cyc(1'b1, 4'b0100, 4'b0000, 32'h0);
    cyc(1'b1, 4'b0100, 4'b0100, 32'h005A_0000);
    chk("mid_q", 32'(bus.Q), 32'h5A);
    chk("mid_gnt", 32'(bus.GNT), 32'h4);
    cyc(1'b0, 4'b0101, 4'b0100, 32'h005A_0000);
    chk("mid_rst_q", 32'(bus.Q), 32'h0);
    chk("mid_rst_gnt", 32'(bus.GNT), 32'h0);
    cyc(1'b1, 4'b0101, 4'b0000, 32'h0);
    chk("mid_next_gnt", 32'(bus.GNT), 32'h1);

    // Hold behaviour: owner 0 keeps REQ high
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0);
    cyc(1'b1, 4'b0011, 4'b0000, 32'h0);
    run   = (bus.GNT == 4'b0001) ? 1 : 0;
    ended = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, 4'b0011, 4'b0000, 32'h0);
      if (!ended && bus.GNT == 4'b0001) run++;
      else ended = 1'b1;
    end
`ifdef ARB_TIMEOUT_EN
    chk("hold_run", 32'(run), 32'd4);
`else
    chk("hold_run", 32'(run), 32'd21);
`endif

    // Randomized traffic with sticky requests and occasional reset
    r_req = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r_req = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 49) != 0), r_req, 4'($urandom_range(0, 15)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
